mem_stall_ctrl: RTL and testbench

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/mem_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_stall_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// Memory stall controller: freezes the core while a memory request is outstanding,
// in fixed-latency or ready-handshake mode. Optional stall counter under MEM_STALL_PERF_EN.
module mem_stall_ctrl #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned WAIT_READY = 0,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
`ifdef MEM_STALL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PERF_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);
  localparam bit               HS_MODE  = (WAIT_READY != 0);
  localparam bit               LAT_ONE  = (LATENCY == 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  // State, countdown and timeout flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state and outputs; stall in IDLE follows the request so the first cycle is frozen
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    stall_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_o = mem_req_i;
        tmo_d   = 1'b0;
        if (mem_req_i) begin
          if (HS_MODE) begin
            if (mem_ready_i) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = TO_LOAD;
            end
          end else if (LAT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        busy_o  = 1'b1;
        stall_o = mem_req_i;
        if (!mem_req_i) begin
          // Core flushed the access: abandon silently
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (HS_MODE && mem_ready_i) begin
            state_d = ST_DONE;
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            tmo_d   = HS_MODE;
          end
        end
      end
      ST_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        err_o   = tmo_q;
        state_d = ST_IDLE;
        tmo_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
    endcase
    if (!rst_i) begin
      stall_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      err_o   = 1'b0;
    end
  end

`ifdef MEM_STALL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;

  // Saturating count of frozen cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: four configurations side by side, outputs checked
// as {stall, busy, done, err} each cycle.
module tb_mem_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic req_l1, req_l4, req_hs, req_l3, rdy;
  logic l1_s, l1_b, l1_d, l1_e;
  logic l4_s, l4_b, l4_d, l4_e;
  logic hs_s, hs_b, hs_d, hs_e;
  logic l3_s, l3_b, l3_d, l3_e;
`ifdef MEM_STALL_PERF_EN
  logic [31:0] l1_c, l4_c, hs_c, l3_c;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stall_ctrl #(.LATENCY(1), .WAIT_READY(0), .TIMEOUT(16)) u_l1 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(req_l1), .mem_ready_i(rdy),
    .stall_o(l1_s), .busy_o(l1_b), .done_o(l1_d), .err_o(l1_e)
`ifdef MEM_STALL_PERF_EN
    , .stall_cnt_o(l1_c)
`endif
  );

  mem_stall_ctrl #(.LATENCY(4), .WAIT_READY(0), .TIMEOUT(16)) u_l4 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(req_l4), .mem_ready_i(rdy),
    .stall_o(l4_s), .busy_o(l4_b), .done_o(l4_d), .err_o(l4_e)
`ifdef MEM_STALL_PERF_EN
    , .stall_cnt_o(l4_c)
`endif
  );

  mem_stall_ctrl #(.LATENCY(1), .WAIT_READY(1), .TIMEOUT(8)) u_hs (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(req_hs), .mem_ready_i(rdy),
    .stall_o(hs_s), .busy_o(hs_b), .done_o(hs_d), .err_o(hs_e)
`ifdef MEM_STALL_PERF_EN
    , .stall_cnt_o(hs_c)
`endif
  );

  mem_stall_ctrl #(.LATENCY(3), .WAIT_READY(0), .TIMEOUT(16)) u_l3 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(req_l3), .mem_ready_i(rdy),
    .stall_o(l3_s), .busy_o(l3_b), .done_o(l3_d), .err_o(l3_e)
`ifdef MEM_STALL_PERF_EN
    , .stall_cnt_o(l3_c)
`endif
  );

  function automatic logic [3:0] obs(input int d);
    case (d)
      1:       return {l1_s, l1_b, l1_d, l1_e};
      4:       return {l4_s, l4_b, l4_d, l4_e};
      8:       return {hs_s, hs_b, hs_d, hs_e};
      default: return {l3_s, l3_b, l3_d, l3_e};
    endcase
  endfunction

  task automatic chk(input string tag, input int d, input logic [3:0] exp);
    logic [3:0] o;
    o = obs(d);
    n_cmp++;
    assert (o === exp) else begin
      n_bad++;
      $error("FAIL %s: observed sbde=%b expected sbde=%b", tag, o, exp);
    end
  endtask

  // Check the current cycle after inputs settle, then move to just past the next edge
  task automatic cyc(input string tag, input int d, input logic [3:0] exp);
    #1;
    chk(tag, d, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req_l1 = 1'b1; req_l4 = 1'b1; req_hs = 1'b1; req_l3 = 1'b1; rdy = 1'b1;
    #2;
    chk("rst_force_l1", 1, 4'b0000);
    chk("rst_force_l4", 4, 4'b0000);
    chk("rst_force_hs", 8, 4'b0000);
    chk("rst_force_l3", 3, 4'b0000);
    @(posedge clk); #1;
    chk("rst_force_l4_edge", 4, 4'b0000);
    req_l1 = 1'b0; req_l4 = 1'b0; req_hs = 1'b0; req_l3 = 1'b0; rdy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc("idle_l1", 1, 4'b0000);

    // LATENCY=1: one stall, then done
    req_l1 = 1'b1;
    cyc("l1_stall", 1, 4'b1000);
    cyc("l1_done", 1, 4'b0110);
    req_l1 = 1'b0;
    cyc("l1_after", 1, 4'b0000);

    // LATENCY=4 with ready toggling (ignored in fixed mode)
    req_l4 = 1'b1; rdy = 1'b1;
    cyc("l4_idle_stall", 4, 4'b1000);
    for (int i = 0; i < 3; i++) cyc("l4_wait", 4, 4'b1100);
    cyc("l4_done", 4, 4'b0110);
    req_l4 = 1'b0; rdy = 1'b0;
    cyc("l4_after", 4, 4'b0000);

    // Handshake: ready in the third stall cycle
    req_hs = 1'b1;
    cyc("hs_c0", 8, 4'b1000);
    cyc("hs_c1", 8, 4'b1100);
    rdy = 1'b1;
    cyc("hs_c2_ready", 8, 4'b1100);
    rdy = 1'b0;
    cyc("hs_done", 8, 4'b0110);
    req_hs = 1'b0;
    cyc("hs_after", 8, 4'b0000);

    // Handshake: ready together with the request goes straight to DONE
    req_hs = 1'b1; rdy = 1'b1;
    cyc("hs_same_stall", 8, 4'b1000);
    rdy = 1'b0;
    cyc("hs_same_done", 8, 4'b0110);
    req_hs = 1'b0;
    cyc("hs_same_after", 8, 4'b0000);

    // Handshake timeout after 8 stalls, then a back-to-back request with flag cleared
    req_hs = 1'b1;
    cyc("to_c0", 8, 4'b1000);
    for (int i = 0; i < 7; i++) cyc("to_wait", 8, 4'b1100);
    rdy = 1'b1;
    cyc("to_done_err", 8, 4'b0111);
    cyc("b2b_stall", 8, 4'b1000);
    rdy = 1'b0;
    cyc("b2b_done_noerr", 8, 4'b0110);
    req_hs = 1'b0;
    cyc("to_after", 8, 4'b0000);

    // Abort in the second WAIT cycle
    req_l4 = 1'b1;
    cyc("ab_c0", 4, 4'b1000);
    cyc("ab_wait1", 4, 4'b1100);
    req_l4 = 1'b0;
    cyc("ab_drop", 4, 4'b0100);
    cyc("ab_idle", 4, 4'b0000);
    cyc("ab_idle2", 4, 4'b0000);

    // Reset mid-WAIT, then a held request restarts from IDLE
    req_l4 = 1'b1;
    cyc("rs_c0", 4, 4'b1000);
    cyc("rs_wait1", 4, 4'b1100);
    rst_n = 1'b0;
    #1;
    chk("rs_now", 4, 4'b0000);
    @(posedge clk); #1;
    chk("rs_hold", 4, 4'b0000);
    rst_n = 1'b1;
    cyc("rs_restart", 4, 4'b1000);
    for (int i = 0; i < 3; i++) cyc("rs_wait", 4, 4'b1100);
    cyc("rs_done", 4, 4'b0110);
    req_l4 = 1'b0;
    cyc("rs_after", 4, 4'b0000);

    // LATENCY=3, two back-to-back requests
    req_l3 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cyc("l3_stall", 3, 4'b1000);
      cyc("l3_wait", 3, 4'b1100);
      cyc("l3_wait", 3, 4'b1100);
      cyc("l3_done", 3, 4'b0110);
    end
    req_l3 = 1'b0;
    cyc("l3_after", 3, 4'b0000);
`ifdef MEM_STALL_PERF_EN
    n_cmp++;
    assert (l3_c === 32'd6) else begin
      n_bad++;
      $error("FAIL l3_stall_cnt: observed %0d expected 6", l3_c);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
